// File: rtl/id_ex_pkg.sv
// Shared decode constants, ALU codes and control bundle for the ID/EX stage.
// Optional operand forwarding is enabled by defining FWD_EN.
package id_ex_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_BEQ  = 4'b0110;
    localparam logic [3:0] ALU_BNE  = 4'b0111;
    localparam logic [3:0] ALU_BGEZ = 4'b1111;

    typedef enum logic [1:0] {
        IMM_REG,
        IMM_SEXT,
        IMM_ZEXT,
        IMM_ZERO
    } imm_sel_e;

    typedef enum logic [1:0] {
        DEST_NONE,
        DEST_RD,
        DEST_RT
    } dest_sel_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// Combinational decode of opcode/funct/rt into ALU code, operand
// selection, destination selection and downstream control.
module alu_ctrl_dec
    import id_ex_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [5:0]    opcode,
    input  logic [5:0]    funct,
    input  logic [RW-1:0] rt,
    output logic [3:0]    alu_ctrl,
    output imm_sel_e      imm_sel,
    output logic          swap,
    output dest_sel_e     dest_sel,
    output ctrl_t         ctrl,
    output logic          illegal
);

    logic is_bgez;

    assign is_bgez = (opcode == OP_REGIMM) && (rt == RW'(1));

    always_comb begin
        alu_ctrl = ALU_ADD;
        imm_sel  = IMM_REG;
        swap     = 1'b0;
        dest_sel = DEST_NONE;
        ctrl     = '0;
        illegal  = 1'b0;
        unique case (1'b1)
            opcode == OP_RTYPE: begin
                dest_sel       = DEST_RD;
                ctrl.reg_write = 1'b1;
                case (funct)
                    F_ADD:   alu_ctrl = ALU_ADD;
                    F_SUB:   alu_ctrl = ALU_SUB;
                    F_AND:   alu_ctrl = ALU_AND;
                    F_NOR:   alu_ctrl = ALU_NOR;
                    F_OR:    alu_ctrl = ALU_OR;
                    F_SLT: begin
                        alu_ctrl = ALU_SLT;
                        swap     = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            opcode == OP_ADDI: begin
                imm_sel        = IMM_SEXT;
                dest_sel       = DEST_RT;
                ctrl.reg_write = 1'b1;
            end
            opcode == OP_ANDI: begin
                alu_ctrl       = ALU_AND;
                imm_sel        = IMM_ZEXT;
                dest_sel       = DEST_RT;
                ctrl.reg_write = 1'b1;
            end
            opcode == OP_ORI: begin
                alu_ctrl       = ALU_OR;
                imm_sel        = IMM_ZEXT;
                dest_sel       = DEST_RT;
                ctrl.reg_write = 1'b1;
            end
            opcode == OP_SLTI: begin
                alu_ctrl       = ALU_SLT;
                imm_sel        = IMM_SEXT;
                swap           = 1'b1;
                dest_sel       = DEST_RT;
                ctrl.reg_write = 1'b1;
            end
            opcode == OP_LW: begin
                imm_sel        = IMM_SEXT;
                dest_sel       = DEST_RT;
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
            end
            opcode == OP_SW: begin
                imm_sel        = IMM_SEXT;
                ctrl.mem_write = 1'b1;
            end
            opcode == OP_BEQ: begin
                alu_ctrl    = ALU_BEQ;
                ctrl.branch = 1'b1;
            end
            opcode == OP_BNE: begin
                alu_ctrl    = ALU_BNE;
                ctrl.branch = 1'b1;
            end
            is_bgez: begin
                alu_ctrl    = ALU_BGEZ;
                imm_sel     = IMM_ZERO;
                ctrl.branch = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register stage feeding the ALU; flush beats stall beats load.
// Define FWD_EN to add MEM/WB operand forwarding ahead of the register bank.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [5:0]    id_opcode,
    input  logic [5:0]    id_funct,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm,
`ifdef FWD_EN
    input  logic          fwd_mem_we,
    input  logic [RW-1:0] fwd_mem_rd,
    input  logic [DW-1:0] fwd_mem_data,
    input  logic          fwd_wb_we,
    input  logic [RW-1:0] fwd_wb_rd,
    input  logic [DW-1:0] fwd_wb_data,
`endif
    output logic          ex_valid,
    output logic [DW-1:0] entr1,
    output logic [DW-1:0] entr2,
    output logic [3:0]    alu_ctrl,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_branch,
    output logic          ex_illegal
);

    logic [3:0] dec_alu;
    imm_sel_e   dec_imm;
    logic       dec_swap;
    dest_sel_e  dec_dest;
    ctrl_t      dec_ctrl;
    logic       dec_illegal;

    alu_ctrl_dec #(.RW(RW)) u_dec (
        .opcode   (id_opcode),
        .funct    (id_funct),
        .rt       (id_rt),
        .alu_ctrl (dec_alu),
        .imm_sel  (dec_imm),
        .swap     (dec_swap),
        .dest_sel (dec_dest),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal)
    );

    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;

`ifdef FWD_EN
    always_comb begin
        rs_val = id_rs_data;
        if (fwd_mem_we && fwd_mem_rd == id_rs && fwd_mem_rd != '0)
            rs_val = fwd_mem_data;
        else if (fwd_wb_we && fwd_wb_rd == id_rs && fwd_wb_rd != '0)
            rs_val = fwd_wb_data;
    end

    always_comb begin
        rt_val = id_rt_data;
        if (fwd_mem_we && fwd_mem_rd == id_rt && fwd_mem_rd != '0)
            rt_val = fwd_mem_data;
        else if (fwd_wb_we && fwd_wb_rd == id_rt && fwd_wb_rd != '0)
            rt_val = fwd_wb_data;
    end
`else
    logic unused_rs;
    assign unused_rs = ^id_rs;
    assign rs_val    = id_rs_data;
    assign rt_val    = id_rt_data;
`endif

    logic          valid_d, valid_q;
    logic [DW-1:0] entr1_d, entr1_q;
    logic [DW-1:0] entr2_d, entr2_q;
    logic [3:0]    alu_d, alu_q;
    logic [DW-1:0] store_d, store_q;
    logic [RW-1:0] dest_d, dest_q;
    ctrl_t         ctrl_d, ctrl_q;
    logic          illegal_d, illegal_q;

    logic [DW-1:0] opb;
    logic [RW-1:0] dest_idx;

    always_comb begin
        opb = rt_val;
        unique case (dec_imm)
            IMM_SEXT: opb = {{(DW-16){id_imm[15]}}, id_imm};
            IMM_ZEXT: opb = {{(DW-16){1'b0}}, id_imm};
            IMM_ZERO: opb = '0;
            default:  opb = rt_val;
        endcase
        dest_idx = '0;
        unique case (dec_dest)
            DEST_RD: dest_idx = id_rd;
            DEST_RT: dest_idx = id_rt;
            default: dest_idx = '0;
        endcase
    end

    always_comb begin
        valid_d   = 1'b0;
        entr1_d   = '0;
        entr2_d   = '0;
        alu_d     = '0;
        store_d   = '0;
        dest_d    = '0;
        ctrl_d    = '0;
        illegal_d = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d   = valid_q;
            entr1_d   = entr1_q;
            entr2_d   = entr2_q;
            alu_d     = alu_q;
            store_d   = store_q;
            dest_d    = dest_q;
            ctrl_d    = ctrl_q;
            illegal_d = illegal_q;
        end else if (id_valid && dec_illegal) begin
            // trap marker travels down the pipe with no side effects
            valid_d   = 1'b1;
            illegal_d = 1'b1;
        end else if (id_valid) begin
            valid_d   = 1'b1;
            // ALU evaluates entr1 > entr2, so slt operands are swapped
            entr1_d   = dec_swap ? opb : rs_val;
            entr2_d   = dec_swap ? rs_val : opb;
            alu_d     = dec_alu;
            store_d   = rt_val;
            dest_d    = dest_idx;
            ctrl_d    = dec_ctrl;
            ctrl_d.reg_write = dec_ctrl.reg_write && (dest_idx != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            entr1_q   <= '0;
            entr2_q   <= '0;
            alu_q     <= '0;
            store_q   <= '0;
            dest_q    <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            entr1_q   <= entr1_d;
            entr2_q   <= entr2_d;
            alu_q     <= alu_d;
            store_q   <= store_d;
            dest_q    <= dest_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid      = valid_q;
    assign entr1         = entr1_q;
    assign entr2         = entr2_q;
    assign alu_ctrl      = alu_q;
    assign ex_store_data = store_q;
    assign ex_dest       = dest_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_branch     = ctrl_q.branch;
    assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
// Forwarding scenarios are exercised when built with FWD_EN.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [15:0] id_imm;
`ifdef FWD_EN
    logic        fwd_mem_we;
    logic [4:0]  fwd_mem_rd;
    logic [31:0] fwd_mem_data;
    logic        fwd_wb_we;
    logic [4:0]  fwd_wb_rd;
    logic [31:0] fwd_wb_data;
`endif
    logic        ex_valid;
    logic [31:0] entr1;
    logic [31:0] entr2;
    logic [3:0]  alu_ctrl;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    // valid, alu_ctrl, dest, {rw, mr, mw, br}, illegal
    logic [14:0]  ctl;
    logic [110:0] all_out;
    assign ctl = {ex_valid, alu_ctrl, ex_dest, ex_reg_write,
                  ex_mem_read, ex_mem_write, ex_branch, ex_illegal};
    assign all_out = {ctl, entr1, entr2, ex_store_data};

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_funct      (id_funct),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm        (id_imm),
`ifdef FWD_EN
        .fwd_mem_we    (fwd_mem_we),
        .fwd_mem_rd    (fwd_mem_rd),
        .fwd_mem_data  (fwd_mem_data),
        .fwd_wb_we     (fwd_wb_we),
        .fwd_wb_rd     (fwd_wb_rd),
        .fwd_wb_data   (fwd_wb_data),
`endif
        .ex_valid      (ex_valid),
        .entr1         (entr1),
        .entr2         (entr2),
        .alu_ctrl      (alu_ctrl),
        .ex_store_data (ex_store_data),
        .ex_dest       (ex_dest),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_branch     (ex_branch),
        .ex_illegal    (ex_illegal)
    );

    task automatic drive_id(input logic v, input logic [5:0] op,
                            input logic [5:0] fn, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [15:0] imm);
        id_valid   = v;
        id_opcode  = op;
        id_funct   = fn;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_rs_data = a;
        id_rt_data = b;
        id_imm     = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 16'h0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want 0", all_out);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (entr1 !== 32'h11 || ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: entr1=%h valid=%b want 11/1", entr1, ex_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_id(1'b1, 6'h00, 6'h22, 5'd1, 5'd2, 5'd4, 32'h30, 32'h5, 16'h0);
        step();
        n_checks++;
        if (ctl !== {1'b1, 4'b0001, 5'd4, 4'b1000, 1'b0} || entr1 !== 32'h30) begin
            n_fail++;
            $display("FAIL reset_first_load: ctl=%h entr1=%h", ctl, entr1);
        end
    endtask

    task automatic test_rtype();
        @(negedge clk);
        drive_id(1'b1, 6'h00, 6'h20, 5'd5, 5'd7, 5'd10, 32'd3, 32'd4, 16'h0);
        step();
        n_checks++;
        if (entr1 !== 32'd3 || entr2 !== 32'd4
            || ctl !== {1'b1, 4'b0000, 5'd10, 4'b1000, 1'b0}) begin
            n_fail++;
            $display("FAIL add: e1=%h e2=%h ctl=%h want 3/4/%h", entr1, entr2, ctl,
                     {1'b1, 4'b0000, 5'd10, 4'b1000, 1'b0});
        end
        @(negedge clk);
        drive_id(1'b1, 6'h00, 6'h27, 5'd5, 5'd7, 5'd0, 32'hF0, 32'h0F, 16'h0);
        step();
        n_checks++;
        if (ctl !== {1'b1, 4'b0011, 5'd0, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL nor_rd0: ctl=%h want %h", ctl, {1'b1, 4'b0011, 5'd0, 4'b0000, 1'b0});
        end
    endtask

    task automatic test_imm();
        @(negedge clk);
        drive_id(1'b1, 6'h0C, 6'h00, 5'd1, 5'd3, 5'd9, 32'h12345678, 32'h99, 16'hFFFF);
        step();
        n_checks++;
        if (entr1 !== 32'h12345678 || entr2 !== 32'h0000FFFF
            || ctl !== {1'b1, 4'b0010, 5'd3, 4'b1000, 1'b0}) begin
            n_fail++;
            $display("FAIL andi: e1=%h e2=%h ctl=%h", entr1, entr2, ctl);
        end
        @(negedge clk);
        drive_id(1'b1, 6'h08, 6'h00, 5'd1, 5'd3, 5'd9, 32'h5, 32'h99, 16'hFFFF);
        step();
        n_checks++;
        if (entr2 !== 32'hFFFFFFFF || alu_ctrl !== 4'b0000) begin
            n_fail++;
            $display("FAIL addi: e2=%h alu=%b want ffffffff/0000", entr2, alu_ctrl);
        end
        @(negedge clk);
        drive_id(1'b1, 6'h0D, 6'h00, 5'd1, 5'd6, 5'd9, 32'h5, 32'h99, 16'h8000);
        step();
        n_checks++;
        if (entr2 !== 32'h00008000 || alu_ctrl !== 4'b0100 || ex_dest !== 5'd6) begin
            n_fail++;
            $display("FAIL ori: e2=%h alu=%b dest=%0d", entr2, alu_ctrl, ex_dest);
        end
        @(negedge clk);
        drive_id(1'b1, 6'h23, 6'h00, 5'd2, 5'd8, 5'd0, 32'h1000, 32'h0, 16'hFFFC);
        step();
        n_checks++;
        if (entr2 !== 32'hFFFFFFFC
            || ctl !== {1'b1, 4'b0000, 5'd8, 4'b1100, 1'b0}) begin
            n_fail++;
            $display("FAIL lw: e2=%h ctl=%h", entr2, ctl);
        end
        @(negedge clk);
        drive_id(1'b1, 6'h2B, 6'h00, 5'd2, 5'd8, 5'd7, 32'h1000, 32'hDEADBEEF, 16'h0004);
        step();
        n_checks++;
        if (entr2 !== 32'h4 || ex_store_data !== 32'hDEADBEEF
            || ctl !== {1'b1, 4'b0000, 5'd0, 4'b0010, 1'b0}) begin
            n_fail++;
            $display("FAIL sw: e2=%h sd=%h ctl=%h", entr2, ex_store_data, ctl);
        end
    endtask

    task automatic test_slt_branch();
        @(negedge clk);
        drive_id(1'b1, 6'h00, 6'h2A, 5'd2, 5'd9, 5'd11, 32'd2, 32'd9, 16'h0);
        step();
        n_checks++;
        if (entr1 !== 32'd9 || entr2 !== 32'd2 || alu_ctrl !== 4'b0101) begin
            n_fail++;
            $display("FAIL slt: e1=%h e2=%h alu=%b want 9/2/0101", entr1, entr2, alu_ctrl);
        end
        @(negedge clk);
        drive_id(1'b1, 6'h0A, 6'h00, 5'd2, 5'd9, 5'd11, 32'd7, 32'd0, 16'hFFFF);
        step();
        n_checks++;
        if (entr1 !== 32'hFFFFFFFF || entr2 !== 32'd7 || ex_dest !== 5'd9) begin
            n_fail++;
            $display("FAIL slti: e1=%h e2=%h dest=%0d", entr1, entr2, ex_dest);
        end
        @(negedge clk);
        drive_id(1'b1, 6'h01, 6'h00, 5'd4, 5'd1, 5'd0, 32'h80000000, 32'h77, 16'h0010);
        step();
        n_checks++;
        if (entr1 !== 32'h80000000 || entr2 !== 32'd0
            || ctl !== {1'b1, 4'b1111, 5'd0, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL bgez: e1=%h e2=%h ctl=%h", entr1, entr2, ctl);
        end
        @(negedge clk);
        drive_id(1'b1, 6'h05, 6'h00, 5'd4, 5'd5, 5'd0, 32'h1, 32'h2, 16'h0008);
        step();
        n_checks++;
        if (entr2 !== 32'h2 || ctl !== {1'b1, 4'b0111, 5'd0, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL bne: e2=%h ctl=%h", entr2, ctl);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        drive_id(1'b1, 6'h3F, 6'h00, 5'd4, 5'd5, 5'd6, 32'h1, 32'h2, 16'h0);
        step();
        n_checks++;
        if (ctl !== {1'b1, 4'b0000, 5'd0, 4'b0000, 1'b1} || entr1 !== 32'h0) begin
            n_fail++;
            $display("FAIL illegal_op: ctl=%h e1=%h", ctl, entr1);
        end
        @(negedge clk);
        drive_id(1'b1, 6'h01, 6'h00, 5'd4, 5'd2, 5'd6, 32'h1, 32'h2, 16'h0);
        step();
        n_checks++;
        if (ex_illegal !== 1'b1 || ex_branch !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_regimm: ill=%b br=%b want 1/0", ex_illegal, ex_branch);
        end
        @(negedge clk);
        drive_id(1'b0, 6'h00, 6'h20, 5'd4, 5'd5, 5'd6, 32'h1, 32'h2, 16'h0);
        step();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL idle_bubble: got %h want 0", all_out);
        end
    endtask

    task automatic test_stall_flush();
        @(negedge clk);
        drive_id(1'b1, 6'h00, 6'h20, 5'd5, 5'd7, 5'd10, 32'd3, 32'd4, 16'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'b1;
            drive_id(1'b1, 6'h00, 6'h22, 5'd1, 5'd2, 5'd12, 32'd100 + i, 32'd50, 16'h0);
            step();
            n_checks++;
            if (entr1 !== 32'd3 || entr2 !== 32'd4
                || ctl !== {1'b1, 4'b0000, 5'd10, 4'b1000, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: e1=%h e2=%h ctl=%h", i, entr1, entr2, ctl);
            end
        end
        @(negedge clk);
        flush = 1'b1;
        step();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL stall_flush: got %h want 0", all_out);
        end
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        step();
        n_checks++;
        if (entr1 !== 32'd102 || alu_ctrl !== 4'b0001) begin
            n_fail++;
            $display("FAIL resume: e1=%h alu=%b want 66/0001", entr1, alu_ctrl);
        end
        @(negedge clk);
        flush = 1'b1;
        step();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL flush_only: got %h want 0", all_out);
        end
        @(negedge clk);
        flush = 1'b0;
    endtask

`ifdef FWD_EN
    task automatic test_forward();
        @(negedge clk);
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd8; fwd_mem_data = 32'hA;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd8; fwd_wb_data  = 32'hB;
        drive_id(1'b1, 6'h00, 6'h20, 5'd8, 5'd3, 5'd1, 32'h1, 32'h2, 16'h0);
        step();
        n_checks++;
        if (entr1 !== 32'hA) begin
            n_fail++;
            $display("FAIL fwd_mem_wins: e1=%h want a", entr1);
        end
        @(negedge clk);
        fwd_mem_we = 1'b0;
        fwd_wb_rd  = 5'd3;
        step();
        n_checks++;
        if (entr1 !== 32'h1 || entr2 !== 32'hB) begin
            n_fail++;
            $display("FAIL fwd_wb_rt: e1=%h e2=%h want 1/b", entr1, entr2);
        end
        @(negedge clk);
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd0;
        drive_id(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd1, 32'h55, 32'h66, 16'h0);
        step();
        n_checks++;
        if (entr1 !== 32'h55 || entr2 !== 32'h66) begin
            n_fail++;
            $display("FAIL fwd_rd0: e1=%h e2=%h want 55/66", entr1, entr2);
        end
        @(negedge clk);
        fwd_mem_we = 1'b0;
        fwd_wb_we  = 1'b0;
    endtask
`endif

    initial begin
`ifdef FWD_EN
        fwd_mem_we = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
        fwd_wb_we  = 1'b0; fwd_wb_rd  = '0; fwd_wb_data  = '0;
`endif
        test_reset();
        test_rtype();
        test_imm();
        test_slt_branch();
        test_illegal();
        test_stall_flush();
`ifdef FWD_EN
        test_forward();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
